// File: rtl/ctrl_sequencer_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcode/funct
// values and every control word the datapath can receive.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Opcodes (instruction bits [DATA_WIDTH-1:DATA_WIDTH-6])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_PUSH  = 6'h3A;
  localparam logic [5:0] OP_POP   = 6'h3B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // FETCH / DECODE / MEM words
  localparam logic [31:0] CW_FETCH     = 32'h0020_0000;
  localparam logic [31:0] CW_DEC_SHORT = 32'h0000_0010;
  localparam logic [31:0] CW_DEC_FULL  = 32'h0000_0050;
  localparam logic [31:0] CW_MEM_RD    = 32'h0060_0000;
  localparam logic [31:0] CW_MEM_WR    = 32'h0090_0000;
  localparam logic [31:0] CW_NOP       = 32'h0000_0040;

  // EXE words
  localparam logic [31:0] EXE_ADD  = 32'h0000_0121;
  localparam logic [31:0] EXE_SUB  = 32'h0000_0122;
  localparam logic [31:0] EXE_AND  = 32'h0000_0124;
  localparam logic [31:0] EXE_OR   = 32'h0000_0128;
  localparam logic [31:0] EXE_SLT  = 32'h0000_0130;
  localparam logic [31:0] EXE_ADDI = 32'h0000_0221;
  localparam logic [31:0] EXE_LS   = 32'h0000_0421;
  localparam logic [31:0] EXE_BR   = 32'h0000_0822;
  localparam logic [31:0] EXE_LUI  = 32'h0000_1000;
  localparam logic [31:0] EXE_JMP  = 32'h0000_2000;
  localparam logic [31:0] EXE_JAL  = 32'h0000_4000;
  localparam logic [31:0] EXE_PUSH = 32'h0000_8022;
  localparam logic [31:0] EXE_POP  = 32'h0000_8021;

  // WB words
  localparam logic [31:0] WB_RTYPE    = 32'h1200_60CB;
  localparam logic [31:0] WB_ADDI     = 32'h1200_40CB;
  localparam logic [31:0] WB_LW       = 32'h1680_48CB;
  localparam logic [31:0] WB_SW       = 32'h0000_00C3;
  localparam logic [31:0] WB_BR_TAKEN = 32'h0000_A04D;
  localparam logic [31:0] WB_BR_SEQ   = 32'h0000_204D;
  localparam logic [31:0] WB_LUI      = 32'h1100_00CB;
  localparam logic [31:0] WB_JMP      = 32'h0001_0040;
  localparam logic [31:0] WB_JAL      = 32'h1101_0040;
  localparam logic [31:0] WB_PUSH     = 32'h0200_00C3;
  localparam logic [31:0] WB_POP      = 32'h1600_48CB;

  function automatic logic is_mem_rd(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_POP);
  endfunction

  function automatic logic is_mem_wr(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/ctrl_word_rom.sv
// Combinational control-word lookup: (state, opcode, funct, zero_q) -> CTRL.
// Unrecognised opcode/funct pairs are flagged and replaced by the NOP word.
module ctrl_word_rom
  import ctrl_sequencer_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero_q,
  output logic [31:0] ctrl,
  output logic        illegal
);

  logic [31:0] exe_word;
  logic [31:0] wb_word;
  logic        short_dec;

  // Per-opcode EXE/WB words, short-decode class and legality
  always_comb begin
    exe_word  = '0;
    wb_word   = '0;
    short_dec = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wb_word = WB_RTYPE;
        case (funct)
          FN_ADD:  exe_word = EXE_ADD;
          FN_SUB:  exe_word = EXE_SUB;
          FN_AND:  exe_word = EXE_AND;
          FN_OR:   exe_word = EXE_OR;
          FN_SLT:  exe_word = EXE_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      OP_ADDI: begin exe_word = EXE_ADDI; wb_word = WB_ADDI; end
      OP_LW:   begin exe_word = EXE_LS;   wb_word = WB_LW;   end
      OP_SW:   begin exe_word = EXE_LS;   wb_word = WB_SW;   end
      OP_BEQ:  begin exe_word = EXE_BR;   wb_word = zero_q ? WB_BR_TAKEN : WB_BR_SEQ; end
      OP_BNE:  begin exe_word = EXE_BR;   wb_word = zero_q ? WB_BR_SEQ : WB_BR_TAKEN; end
      OP_LUI:  begin exe_word = EXE_LUI;  wb_word = WB_LUI;  short_dec = 1'b1; end
      OP_JMP:  begin exe_word = EXE_JMP;  wb_word = WB_JMP;  short_dec = 1'b1; end
      OP_JAL:  begin exe_word = EXE_JAL;  wb_word = WB_JAL;  short_dec = 1'b1; end
      OP_PUSH: begin exe_word = EXE_PUSH; wb_word = WB_PUSH; short_dec = 1'b1; end
      OP_POP:  begin exe_word = EXE_POP;  wb_word = WB_POP;  short_dec = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  // Select the word for the current state; illegal ops become NOP in EXE/WB
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH:  ctrl = CW_FETCH;
      S_DECODE: ctrl = short_dec ? CW_DEC_SHORT : CW_DEC_FULL;
      S_EXE:    ctrl = illegal ? CW_NOP : exe_word;
      S_MEM: begin
        if (is_mem_rd(opcode))      ctrl = CW_MEM_RD;
        else if (is_mem_wr(opcode)) ctrl = CW_MEM_WR;
        else                        ctrl = '0;
      end
      S_WB:     ctrl = illegal ? CW_NOP : wb_word;
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXE/[MEM]/WB with memory
// handshake, timeout fault, halt support and a retired-instruction counter.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int SKIP_MEM   = 1,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION,
  input  logic                  ZERO,
  input  logic                  MEM_READY,
  input  logic                  HALT,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE,
  output logic [2:0]            STATE,
  output logic                  INSTR_DONE,
  output logic                  ILLEGAL,
  output logic                  FAULT,
  output logic [CNT_WIDTH-1:0]  RETIRED
);

  localparam int WW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIM_W = WW'(WAIT_LIMIT);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic                  zero_q_reg;
  logic                  illegal_reg;
  logic [WW-1:0]         wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0]  retired_reg;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rom_ctrl;
  logic        rom_illegal;
  logic        mem_rd, mem_wr, mem_strobe;
  logic        waiting, timeout;
  logic        unused_ir_bits;

  assign opcode         = ir_reg[DATA_WIDTH-1 -: 6];
  assign funct          = ir_reg[5:0];
  assign unused_ir_bits = &{1'b0, ir_reg[DATA_WIDTH-7:6]};

  assign mem_rd     = is_mem_rd(opcode);
  assign mem_wr     = is_mem_wr(opcode);
  assign mem_strobe = (state_reg == S_MEM) && (mem_rd || mem_wr);

  // Timeout only counts cycles where the memory is actually being waited on
  assign waiting = ((state_reg == S_FETCH) || mem_strobe) && !MEM_READY;
  assign timeout = (WAIT_LIMIT != 0) && waiting && (wait_cnt_reg == WAIT_LIM_W);

  ctrl_word_rom u_rom (
    .state   (state_reg),
    .opcode  (opcode),
    .funct   (funct),
    .zero_q  (zero_q_reg),
    .ctrl    (rom_ctrl),
    .illegal (rom_illegal)
  );

  // Next-state and wait-counter logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = (waiting && !timeout) ? wait_cnt_reg + 1'b1 : '0;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH: begin
        if (MEM_READY)    state_next = S_DECODE;
        else if (timeout) state_next = S_FAULT;
      end
      S_DECODE: state_next = S_EXE;
      S_EXE: begin
        if (illegal_reg)                            state_next = S_WB;
        else if ((SKIP_MEM == 0) || mem_rd || mem_wr) state_next = S_MEM;
        else                                        state_next = S_WB;
      end
      S_MEM: begin
        if (!mem_strobe || MEM_READY) state_next = S_WB;
        else if (timeout)             state_next = S_FAULT;
      end
      S_WB:     state_next = HALT ? S_HALTED : S_FETCH;
      S_HALTED: if (!HALT) state_next = S_FETCH;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_IDLE;
    endcase
  end

  // State, instruction register, sampled flags and retired counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      ir_reg       <= '0;
      zero_q_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if ((state_reg == S_FETCH) && MEM_READY) ir_reg <= INSTRUCTION;
      if (state_reg == S_DECODE) illegal_reg <= rom_illegal;
      if (state_reg == S_EXE)    zero_q_reg  <= ZERO;
      if (state_reg == S_WB)     retired_reg <= retired_reg + 1'b1;
    end
  end

  assign CTRL       = CTRL_WIDTH'(rom_ctrl);
  assign READ       = (state_reg == S_FETCH) || ((state_reg == S_MEM) && mem_rd);
  assign WRITE      = (state_reg == S_MEM) && mem_wr;
  assign STATE      = state_reg;
  assign INSTR_DONE = (state_reg == S_WB);
  assign ILLEGAL    = (state_reg == S_WB) && illegal_reg;
  assign FAULT      = (state_reg == S_FAULT);
  assign RETIRED    = retired_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: table of single-instruction runs plus
// hand-written sequences for wait states, halt, timeout and reset.
module tb_ctrl_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic        ZERO = 1'b0;
  logic        MEM_READY = 1'b0;
  logic        HALT = 1'b0;

  logic [31:0] CTRL, l_CTRL;
  logic        READ, WRITE, INSTR_DONE, ILLEGAL, FAULT;
  logic        l_READ, l_WRITE, l_INSTR_DONE, l_ILLEGAL, l_FAULT;
  logic [2:0]  STATE, l_STATE;
  logic [15:0] RETIRED, l_RETIRED;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_retired = 0;

  always #5 CLK = ~CLK;

  ctrl_sequencer #(.SKIP_MEM(1), .WAIT_LIMIT(15)) dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .HALT(HALT), .CTRL(CTRL), .READ(READ),
    .WRITE(WRITE), .STATE(STATE), .INSTR_DONE(INSTR_DONE),
    .ILLEGAL(ILLEGAL), .FAULT(FAULT), .RETIRED(RETIRED)
  );

  ctrl_sequencer #(.SKIP_MEM(0), .WAIT_LIMIT(15)) dut_legacy (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .HALT(HALT), .CTRL(l_CTRL), .READ(l_READ),
    .WRITE(l_WRITE), .STATE(l_STATE), .INSTR_DONE(l_INSTR_DONE),
    .ILLEGAL(l_ILLEGAL), .FAULT(l_FAULT), .RETIRED(l_RETIRED)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [31:0] dec;
    logic [31:0] exe;
    logic [31:0] wb;
    logic        rd;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One instruction from FETCH back to FETCH with READY held high
  task automatic run_vec(input int idx, input vec_t v);
    INSTRUCTION = v.instr;
    ZERO        = v.zero;
    MEM_READY   = 1'b1;
    chk("fetch_state", 32'(STATE), 32'd1);
    chk("fetch_read", 32'(READ), 32'd1);
    chk("fetch_ctrl", CTRL, 32'h0020_0000);
    tick();
    chk("dec_state", 32'(STATE), 32'd2);
    chk("dec_ctrl", CTRL, v.dec);
    chk("dec_strobes", {30'd0, READ, WRITE}, 32'd0);
    tick();
    chk("exe_state", 32'(STATE), 32'd3);
    chk("exe_ctrl", CTRL, v.exe);
    chk("exe_strobes", {30'd0, READ, WRITE}, 32'd0);
    tick();
    ZERO = ~v.zero;
    if (v.rd || v.wr) begin
      chk("mem_state", 32'(STATE), 32'd4);
      chk("mem_read", 32'(READ), 32'(v.rd));
      chk("mem_write", 32'(WRITE), 32'(v.wr));
      chk("mem_ctrl", CTRL, v.rd ? 32'h0060_0000 : 32'h0090_0000);
      tick();
    end
    chk("wb_state", 32'(STATE), 32'd5);
    chk("wb_ctrl", CTRL, v.wb);
    chk("wb_done", 32'(INSTR_DONE), 32'd1);
    chk("wb_illegal", 32'(ILLEGAL), 32'(v.ill));
    chk("wb_strobes", {30'd0, READ, WRITE}, 32'd0);
    chk("wb_retired", 32'(RETIRED), 32'(exp_retired));
    tick();
    exp_retired++;
    chk("post_state", 32'(STATE), 32'd1);
    chk("post_done", 32'(INSTR_DONE), 32'd0);
    chk("post_retired", 32'(RETIRED), 32'(exp_retired));
    $display("vec %0d instr=0x%08h zero=%0d wb_expected=0x%08h retired=%0d", idx, v.instr, v.zero, v.wb, RETIRED);
  endtask

  initial begin
    vecs[0]  = '{32'h0022_1820, 1'b0, 32'h50, 32'h0121, 32'h1200_60CB, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h0022_1822, 1'b1, 32'h50, 32'h0122, 32'h1200_60CB, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h8C22_0004, 1'b0, 32'h50, 32'h0421, 32'h1680_48CB, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'hAC22_0004, 1'b0, 32'h50, 32'h0421, 32'h0000_00C3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h1022_0003, 1'b1, 32'h50, 32'h0822, 32'h0000_A04D, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h1022_0003, 1'b0, 32'h50, 32'h0822, 32'h0000_204D, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h1422_0003, 1'b1, 32'h50, 32'h0822, 32'h0000_204D, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h1422_0003, 1'b0, 32'h50, 32'h0822, 32'h0000_A04D, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h3C01_1234, 1'b0, 32'h10, 32'h1000, 32'h1100_00CB, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0C00_0010, 1'b0, 32'h10, 32'h4000, 32'h1101_0040, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h2022_0005, 1'b0, 32'h50, 32'h0221, 32'h1200_40CB, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'hE800_0000, 1'b0, 32'h10, 32'h8022, 32'h0200_00C3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'hEC00_0000, 1'b0, 32'h10, 32'h8021, 32'h1600_48CB, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'hFC00_0000, 1'b0, 32'h50, 32'h0040, 32'h0000_0040, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{32'h0022_183F, 1'b0, 32'h50, 32'h0040, 32'h0000_0040, 1'b0, 1'b0, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_ctrl", CTRL, 32'd0);
    chk("rst_strobes", {30'd0, READ, WRITE}, 32'd0);
    chk("rst_flags", {29'd0, INSTR_DONE, ILLEGAL, FAULT}, 32'd0);
    chk("rst_retired", 32'(RETIRED), 32'd0);
    $display("reset checked");

    // IDLE -> FETCH, then FETCH holds while READY low
    RST = 1'b0;
    tick();
    chk("idle_to_fetch", 32'(STATE), 32'd1);
    tick();
    tick();
    chk("fetch_hold", 32'(STATE), 32'd1);
    chk("fetch_hold_read", 32'(READ), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // lw with three READY-low cycles in MEM: 8 cycles from FETCH to WB
    INSTRUCTION = 32'h8C22_0004;
    MEM_READY = 1'b1;
    chk("lw_c1_fetch", 32'(STATE), 32'd1);
    tick();
    tick();
    MEM_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) MEM_READY = 1'b1;
      chk("lw_mem_state", 32'(STATE), 32'd4);
      chk("lw_mem_read", 32'(READ), 32'd1);
    end
    tick();
    chk("lw_c8_wb_state", 32'(STATE), 32'd5);
    chk("lw_wb_ctrl", CTRL, 32'h1680_48CB);
    tick();
    exp_retired++;
    chk("lw_retired", 32'(RETIRED), 32'(exp_retired));
    $display("lw wait-state sequence done");

    // HALT ignored outside WB, honoured in WB, released from HALTED
    INSTRUCTION = 32'h0022_1820;
    tick();
    HALT = 1'b1;
    tick();
    chk("halt_ignored_exe", 32'(STATE), 32'd3);
    tick();
    chk("halt_wb", 32'(STATE), 32'd5);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("halted_state", 32'(STATE), 32'd6);
      chk("halted_ctrl", CTRL, 32'd0);
      chk("halted_strobes", {30'd0, READ, WRITE}, 32'd0);
    end
    HALT = 1'b0;
    tick();
    exp_retired++;
    chk("halt_release", 32'(STATE), 32'd1);
    chk("halt_retired", 32'(RETIRED), 32'(exp_retired));
    $display("halt sequence done");

    // READY arriving on the limit cycle completes normally
    MEM_READY = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    chk("limit_still_fetch", 32'(STATE), 32'd1);
    MEM_READY = 1'b1;
    tick();
    chk("limit_ready_decode", 32'(STATE), 32'd2);
    chk("limit_no_fault", 32'(FAULT), 32'd0);
    tick();
    tick();
    tick();
    exp_retired++;
    chk("limit_back_fetch", 32'(STATE), 32'd1);
    $display("limit-cycle ready sequence done");

    // READY stuck low in FETCH: fault after 16 FETCH cycles
    MEM_READY = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    chk("to_16th_fetch", 32'(STATE), 32'd1);
    tick();
    chk("fault_state", 32'(STATE), 32'd7);
    chk("fault_flag", 32'(FAULT), 32'd1);
    chk("fault_read", 32'(READ), 32'd0);
    chk("fault_ctrl", CTRL, 32'd0);
    MEM_READY = 1'b1;
    tick();
    tick();
    chk("fault_sticky", 32'(STATE), 32'd7);
    RST = 1'b1;
    #1;
    chk("fault_rst_state", 32'(STATE), 32'd0);
    chk("fault_rst_flag", 32'(FAULT), 32'd0);
    tick();
    RST = 1'b0;
    exp_retired = 0;
    chk("fault_rst_retired", 32'(RETIRED), 32'd0);
    $display("timeout sequence done");

    // Legacy fixed cycle: add visits MEM with no strobe
    INSTRUCTION = 32'h0022_1820;
    MEM_READY = 1'b1;
    tick();
    chk("leg_fetch", 32'(l_STATE), 32'd1);
    tick();
    chk("leg_decode", 32'(l_STATE), 32'd2);
    tick();
    chk("leg_exe", 32'(l_STATE), 32'd3);
    tick();
    chk("leg_mem", 32'(l_STATE), 32'd4);
    chk("leg_mem_strobes", {30'd0, l_READ, l_WRITE}, 32'd0);
    chk("leg_mem_ctrl", l_CTRL, 32'd0);
    tick();
    chk("leg_wb", 32'(l_STATE), 32'd5);
    chk("leg_wb_ctrl", l_CTRL, 32'h1200_60CB);
    tick();
    chk("leg_refetch", 32'(l_STATE), 32'd1);
    chk("leg_retired", 32'(l_RETIRED), 32'd1);
    $display("legacy five-state sequence done");

    // Asynchronous reset during a pending lw access drops READ at once
    INSTRUCTION = 32'h8C22_0004;
    tick();
    tick();
    MEM_READY = 1'b0;
    tick();
    chk("abort_mem_read", 32'(READ), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_read_low", 32'(READ), 32'd0);
    chk("abort_state", 32'(STATE), 32'd0);
    tick();
    RST = 1'b0;
    $display("async abort sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Parametrised multi-cycle control sequencer, the successor to the fixed five-state processor controller.
- Adds variable-latency memory handshake (MEM_READY) with timeout fault, an internally latched instruction register and a sampled ZERO flag.
- Optional skip of the MEM state for non-memory ops, a HALT state, illegal-opcode detection and a retired-instruction counter.
- Sits between memory/register file/ALU and drives the datapath CTRL word, READ and WRITE.

Parameters:
DATA_WIDTH, 32, instruction width; opcode = [DATA_WIDTH-1:DATA_WIDTH-6], funct = [5:0]
CTRL_WIDTH, 32, datapath control word width
SKIP_MEM, 1, 1: MEM state only for lw/sw/push/pop; 0: legacy fixed 5-state cycle
WAIT_LIMIT, 15, max consecutive MEM_READY-low cycles in FETCH/MEM before FAULT; 0 disables timeout
CNT_WIDTH, 16, width of RETIRED counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
INSTRUCTION  in  DATA_WIDTH  memory read data during FETCH
ZERO  in  1  ALU zero status
MEM_READY  in  1  memory access complete this cycle
HALT  in  1  stop request, sampled in WB and HALTED
CTRL  out  CTRL_WIDTH  datapath control word
READ  out  1  memory read strobe
WRITE  out  1  memory write strobe
STATE  out  3  current state encoding
INSTR_DONE  out  1  one-cycle pulse in WB
ILLEGAL  out  1  high during WB of an unrecognised opcode/funct
FAULT  out  1  sticky memory-timeout flag
RETIRED  out  CNT_WIDTH  count of completed WB states

Behaviour:
- Clock and reset: one clock CLK; RST asynchronous, active-high.
- Reset values: state=IDLE, IR=0, zero_q=0, wait_cnt=0, RETIRED=0, FAULT=0. CTRL=0, READ=0, WRITE=0, INSTR_DONE=0, ILLEGAL=0.
- Reset mid-operation aborts any access immediately. READ/WRITE drop asynchronously.
- States: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- Outputs are Moore: functions of state, IR, zero_q only. No combinational path from inputs to outputs.
- IDLE: first edge after RST deassert goes to FETCH.
- FETCH:
  - READ=1, CTRL=0x00200000.
  - Holds while MEM_READY=0.
  - On the edge with MEM_READY=1: IR<=INSTRUCTION, go to DECODE. Single-cycle access is legal.
- DECODE, 1 cycle: CTRL=0x00000010 for lui/jmp/jal/push/pop, else 0x00000050. Illegal-op flag is computed here and registered.
- EXE, 1 cycle:
  - CTRL from the EXE table.
  - zero_q<=ZERO on exit edge.
  - Next state is MEM if (SKIP_MEM=0 or op in {lw,sw,push,pop}), else WB.
- MEM:
  - lw/pop: READ=1. sw/push: WRITE=1. Other ops with SKIP_MEM=0: no strobe, 1 cycle.
  - Strobed access holds until MEM_READY=1, then goes to WB.
- WB, 1 cycle:
  - CTRL from WB table; beq/bne select PC word using zero_q.
  - INSTR_DONE=1, RETIRED+1 with wrap to 0.
  - ILLEGAL=1 if illegal; that op gets NOP CTRL=0x00000040 in EXE/WB, with no MEM and no register write.
  - Next state: HALTED if HALT=1, else FETCH.
- HALTED: CTRL=0, no strobes. Goes to FETCH on the first edge with HALT=0.
- Timeout:
  - wait_cnt increments each cycle in FETCH or strobed MEM with MEM_READY=0. It clears on READY or state change.
  - If WAIT_LIMIT≠0 and wait_cnt==WAIT_LIMIT with READY still 0, next state is FAULT and FAULT=1.
  - FAULT is terminal until RST: strobes 0, CTRL=0.
- Simultaneous events: READY=1 on the limit cycle completes normally, no fault. HALT is ignored outside WB/HALTED.

Decomposition:
- Shared package: state encodings, opcode/funct constants, and the full FETCH/DECODE/EXE/MEM/WB control-word constants.
- Sub-module ctrl_word_rom: combinational (state, opcode, funct, zero_q) → CTRL, illegal.
- ctrl_sequencer holds the FSM, IR, zero_q, wait_cnt, RETIRED.

Test Plan:
- add 0x00221820, READY tied 1, SKIP_MEM=1:
  - STATE sequence 1,2,3,5,1.
  - WB CTRL=0x120060CB, INSTR_DONE one pulse, RETIRED 0→1.
- lw 0x8C220004 with READY low 3 cycles in MEM:
  - READ held 4 MEM cycles, then WB CTRL=0x168048CB.
  - Total 8 cycles.
- beq with ZERO=1 during EXE then ZERO=0 in WB: WB CTRL=0x0000A04D, proving zero_q is used.
- READY stuck 0 in FETCH, WAIT_LIMIT=15:
  - FAULT after 16 FETCH cycles, STATE=7, READ=0.
  - Stays until RST pulse, which returns IDLE with FAULT=0.
- HALT=1 at WB: STATE=6 for 5 cycles, then HALT=0 gives FETCH next edge.
- Opcode 0x3F: ILLEGAL=1 in WB, no READ/WRITE after FETCH, RETIRED increments. SKIP_MEM=0 run of add visits MEM (5 states).
